// File: rtl/pla_tt_capture.sv
// Sweep-and-capture stage: drives every minterm onto x0..x5, samples y0, and hands
// the assembled truth table downstream. Optional autosymmetry check: PLA_TT_AUTOSYM_CHECK_EN.
module pla_tt_capture #(
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned SETTLE = 0,
  localparam int unsigned TT_W  = 1 << NUM_IN,
  localparam int unsigned CNT_W = NUM_IN + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              x0,
  output logic              x1,
  output logic              x2,
  output logic              x3,
  output logic              x4,
  output logic              x5,
  input  logic              y0,
  output logic              busy,
  output logic              tt_valid,
  input  logic              tt_ready,
`ifdef PLA_TT_AUTOSYM_CHECK_EN
  input  logic [NUM_IN-1:0] alpha,
  output logic              sym_ok,
`endif
  output logic [TT_W-1:0]   tt_data,
  output logic [CNT_W-1:0]  ones_count
);

  localparam int unsigned SET_W = 4;
  localparam int unsigned X_W   = 6;
  localparam logic [NUM_IN-1:0] IDX_LAST = NUM_IN'(TT_W - 1);
  localparam logic [SET_W-1:0]  SET_LD   = SET_W'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
`ifdef PLA_TT_AUTOSYM_CHECK_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_IN-1:0]  idx_q, idx_d;
  logic [NUM_IN-1:0]  x_q, x_d;
  logic [SET_W-1:0]   cnt_q, cnt_d;
  logic [TT_W-1:0]    tt_data_q, tt_data_d;
  logic [CNT_W-1:0]   ones_q, ones_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic [X_W-1:0]     x_out;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
  logic [NUM_IN-1:0]  alpha_q, alpha_d;
  logic               sym_q, sym_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      x_q       <= '0;
      cnt_q     <= '0;
      tt_data_q <= '0;
      ones_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
      alpha_q   <= '0;
      sym_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      tt_data_q <= tt_data_d;
      ones_q    <= ones_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
      alpha_q   <= alpha_d;
      sym_q     <= sym_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    tt_data_d = tt_data_q;
    ones_d    = ones_q;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
    alpha_d   = alpha_q;
    sym_d     = sym_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_DRIVE;
          idx_d     = '0;
          x_d       = '0;
          cnt_d     = SET_LD;
          tt_data_d = '0;
          ones_d    = '0;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
          alpha_d   = alpha;
`endif
        end
      end

      S_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SET_W'(1);
        end else begin
          tt_data_d[idx_q] = y0;
          ones_d           = ones_q + CNT_W'(y0);
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + NUM_IN'(1);
            x_d   = idx_q + NUM_IN'(1);
            cnt_d = SET_LD;
          end else begin
`ifdef PLA_TT_AUTOSYM_CHECK_EN
            state_d = S_CHECK;
            idx_d   = '0;
            sym_d   = 1'b1;
`else
            state_d = S_DONE;
`endif
          end
        end
      end

`ifdef PLA_TT_AUTOSYM_CHECK_EN
      // One table position per cycle against its alpha-shifted partner
      S_CHECK: begin
        if (tt_data_q[idx_q] != tt_data_q[idx_q ^ alpha_q]) begin
          sym_d = 1'b0;
        end
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + NUM_IN'(1);
        end
      end
`endif

      S_DONE: begin
        if (valid_q && tt_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
  end

  assign x_out      = X_W'(x_q);
  assign x0         = x_out[0];
  assign x1         = x_out[1];
  assign x2         = x_out[2];
  assign x3         = x_out[3];
  assign x4         = x_out[4];
  assign x5         = x_out[5];
  assign busy       = busy_q;
  assign tt_valid   = valid_q;
  assign tt_data    = tt_data_q;
  assign ones_count = ones_q;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
  assign sym_ok     = sym_q;
`endif

endmodule

// File: tb/tb_pla_tt_capture.sv
// Directed bench for pla_tt_capture: one instance with SETTLE=0 and a selectable
// function, one with SETTLE=2 driving y0 = x5 & x4.
`timescale 1ns/1ps
module tb_pla_tt_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start0, start2, rdy0, rdy2;
  logic        y0_0, y0_2;
  logic [5:0]  xv0, xv2;
  logic        busy0, busy2, val0, val2;
  logic [63:0] td0, td2;
  logic [6:0]  oc0, oc2;
  int          mode;
  int          n_vec = 0;
  int          n_err = 0;
  logic [5:0]  xs [8];
`ifdef PLA_TT_AUTOSYM_CHECK_EN
  logic [5:0]  alpha;
  logic        sym_ok;
  logic [5:0]  alpha2;
  logic        sym_ok2;
  localparam int EXT = 64;
`else
  localparam int EXT = 0;
`endif
  localparam int LAT0 = 64 + EXT;
  localparam int LAT2 = 192 + EXT;

  // Function under characterisation for the SETTLE=0 instance
  always_comb begin
    case (mode)
      0:       y0_0 = 1'b0;
      1:       y0_0 = xv0[0];
      2:       y0_0 = 1'b1;
      default: y0_0 = xv0[0] ^ xv0[1];
    endcase
  end
  assign y0_2 = xv2[5] & xv2[4];

  pla_tt_capture #(.NUM_IN(6), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .x0(xv0[0]), .x1(xv0[1]), .x2(xv0[2]), .x3(xv0[3]), .x4(xv0[4]), .x5(xv0[5]),
    .y0(y0_0), .busy(busy0), .tt_valid(val0), .tt_ready(rdy0),
`ifdef PLA_TT_AUTOSYM_CHECK_EN
    .alpha(alpha), .sym_ok(sym_ok),
`endif
    .tt_data(td0), .ones_count(oc0)
  );

  pla_tt_capture #(.NUM_IN(6), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
    .x0(xv2[0]), .x1(xv2[1]), .x2(xv2[2]), .x3(xv2[3]), .x4(xv2[4]), .x5(xv2[5]),
    .y0(y0_2), .busy(busy2), .tt_valid(val2), .tt_ready(rdy2),
`ifdef PLA_TT_AUTOSYM_CHECK_EN
    .alpha(alpha2), .sym_ok(sym_ok2),
`endif
    .tt_data(td2), .ones_count(oc2)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Pulse start on one instance and count edges until tt_valid; records x for the first cycles
  task automatic sweep(input bit d2, input int exp_lat, input string tag);
    int   n;
    logic v;
    if (d2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    n = 0;
    xs[0] = d2 ? xv2 : xv0;
    v = d2 ? val2 : val0;
    while (!v && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n < 8) xs[n] = d2 ? xv2 : xv0;
      v = d2 ? val2 : val0;
    end
    check_val(tag, 64'(n), 64'(exp_lat));
  endtask

  task automatic handshake(input bit d2, input string tag);
    if (d2) rdy2 = 1'b1; else rdy0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    rdy2 = 1'b0;
    check_val({tag, "_valid"}, 64'(d2 ? val2 : val0), 64'd0);
    check_val({tag, "_busy"},  64'(d2 ? busy2 : busy0), 64'd0);
  endtask

  initial begin
    int   n;
    logic ok;
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; rdy0 = 1'b0; rdy2 = 1'b0; mode = 1;
`ifdef PLA_TT_AUTOSYM_CHECK_EN
    alpha = '0; alpha2 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy0", 64'(busy0), 64'd0);
    check_val("rst_valid0", 64'(val0), 64'd0);
    check_val("rst_x0", 64'(xv0), 64'd0);
    check_val("rst_data0", td0, 64'd0);
    check_val("rst_ones0", 64'(oc0), 64'd0);
    check_val("rst_busy2", 64'(busy2), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // y0 = x0
    mode = 1;
    sweep(1'b0, LAT0, "lat_x0");
    check_val("x0_first", 64'(xs[0]), 64'd0);
    check_val("x0_second", 64'(xs[1]), 64'd1);
    check_val("data_x0", td0, 64'hAAAA_AAAA_AAAA_AAAA);
    check_val("ones_x0", 64'(oc0), 64'd32);
    handshake(1'b0, "hs_x0");

    // SETTLE=2, y0 = x5 & x4
    sweep(1'b1, LAT2, "lat_x5x4");
    check_val("hold_c2", 64'(xs[2]), 64'd0);
    check_val("hold_c3", 64'(xs[3]), 64'd1);
    check_val("hold_c6", 64'(xs[6]), 64'd2);
    check_val("data_x5x4", td2, 64'hFFFF_0000_0000_0000);
    check_val("ones_x5x4", 64'(oc2), 64'd16);
    handshake(1'b1, "hs_x5x4");

    // y0 = 0, downstream stalls 10 cycles, start pulsed while waiting
    mode = 0;
    sweep(1'b0, LAT0, "lat_zero");
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      start0 = (i == 4);
      if (!(val0 && busy0 && td0 == 64'd0 && oc0 == 7'd0)) ok = 1'b0;
    end
    start0 = 1'b0;
    check_val("stall_stable", 64'(ok), 64'd1);
    rdy0 = 1'b1;
    start0 = 1'b1;
    @(posedge clk); #1;
    rdy0 = 1'b0;
    start0 = 1'b0;
    check_val("stall_hs_valid", 64'(val0), 64'd0);
    check_val("stall_hs_busy", 64'(busy0), 64'd0);
    @(posedge clk); #1;
    check_val("no_restart", 64'(busy0), 64'd0);

    // Reset in the middle of a sweep
    mode = 1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    n = 0;
    while (xv0 != 6'd20 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("reach_idx20", 64'(xv0), 64'd20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("abort_busy", 64'(busy0), 64'd0);
    check_val("abort_valid", 64'(val0), 64'd0);
    check_val("abort_x", 64'(xv0), 64'd0);
    check_val("abort_ones", 64'(oc0), 64'd0);
    check_val("abort_data", td0, 64'd0);
    @(posedge clk); #1;

    // y0 = 1 fills the table and the top counter value
    mode = 2;
    sweep(1'b0, LAT0, "lat_ones");
    check_val("data_ones", td0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("ones_full", 64'(oc0), 64'd64);
    handshake(1'b0, "hs_ones");

    // Back-to-back sweeps
    mode = 1;
    sweep(1'b0, LAT0, "lat_b2b_a");
    handshake(1'b0, "hs_b2b_a");
    sweep(1'b0, LAT0, "lat_b2b_b");
    check_val("data_b2b", td0, 64'hAAAA_AAAA_AAAA_AAAA);
    check_val("ones_b2b", 64'(oc0), 64'd32);
    handshake(1'b0, "hs_b2b_b");

`ifdef PLA_TT_AUTOSYM_CHECK_EN
    // y0 = x0 ^ x1 against several alpha vectors
    mode = 3;
    alpha = 6'b000011;
    sweep(1'b0, LAT0, "lat_sym3");
    check_val("data_xor", td0, 64'h6666_6666_6666_6666);
    check_val("sym_a3", 64'(sym_ok), 64'd1);
    handshake(1'b0, "hs_sym3");
    alpha = 6'b000001;
    sweep(1'b0, LAT0, "lat_sym1");
    check_val("sym_a1", 64'(sym_ok), 64'd0);
    handshake(1'b0, "hs_sym1");
    alpha = 6'b000000;
    sweep(1'b0, LAT0, "lat_sym0");
    check_val("sym_a0", 64'(sym_ok), 64'd1);
    handshake(1'b0, "hs_sym0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
